// File: rtl/axis_pkt_source.sv
// axis_pkt_source
//
// AXI-Stream master that emits one packet of arithmetic-progression words per
// start request. The first beat carries start_value; each later beat adds
// stride (wrapping mod 2^32). Every output comes straight from a register, so
// there is no combinational path from m00_axis_tready to tvalid/tdata/tlast.
//
// Ports
//   m00_axis_aclk      in   sole clock, rising edge
//   m00_axis_areset    in   synchronous active-high reset
//   start              in   one-cycle request, honoured only while idle
//   pkt_len            in   number of beats (sampled with start); 0 = empty packet
//   start_value        in   payload of the first beat (sampled with start)
//   stride             in   increment between beats (sampled with start)
//   busy               out  high while sending or finishing a packet
//   done               out  one-cycle pulse after the packet completes
//   m00_axis_tdata     out  beat payload
//   m00_axis_tstrb     out  byte strobes, always all ones
//   m00_axis_tvalid    out  beat valid
//   m00_axis_tready    in   downstream accepts the beat
//   m00_axis_tlast     out  final beat of the packet
//
// Optional build: define AXIS_PKT_SOURCE_STATS_EN to add
//   pkt_count          out  packets completed (final handshakes), wraps
//   stall_count        out  cycles with tvalid=1 and tready=0, wraps

module axis_pkt_source #(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH              = 16
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_areset,
    input  logic                                  start,
    input  logic [LEN_WIDTH-1:0]                  pkt_len,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     start_value,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     stride,
    output logic                                  busy,
    output logic                                  done,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tlast
`ifdef AXIS_PKT_SOURCE_STATS_EN
    ,
    output logic [31:0]                           pkt_count,
    output logic [31:0]                           stall_count
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]                        state_q, state_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]              cnt_q, cnt_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;
    logic                              done_q, done_d;
    logic                              busy_q, busy_d;
    logic                              handshake;
    logic                              final_beat;

    assign handshake  = tvalid_q && m00_axis_tready;
    assign final_beat = (state_q == StSend) && handshake && (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (pkt_len != '0) begin
                        state_d  = StSend;
                        tdata_d  = start_value;
                        stride_d = stride;
                        cnt_d    = pkt_len - LEN_WIDTH'(1);
                        tvalid_d = 1'b1;
                        tlast_d  = (pkt_len == LEN_WIDTH'(1));
                    end else begin
                        // Empty packet: enter DONE with the pulse still pending,
                        // so DONE lasts two cycles and done fires on the second.
                        state_d = StDone;
                    end
                end
            end

            StSend: begin
                if (handshake) begin
                    if (cnt_q == '0) begin
                        state_d  = StDone;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        tdata_d = tdata_q + stride_q;
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        tlast_d = (cnt_q == LEN_WIDTH'(1));
                    end
                end
            end

            StDone: begin
                if (done_q) begin
                    state_d = StIdle;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d  = StIdle;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == StSend) || (state_d == StDone);
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q  <= StIdle;
            tdata_q  <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;

`ifdef AXIS_PKT_SOURCE_STATS_EN
    logic [31:0] pkt_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            pkt_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if (final_beat) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            if (tvalid_q && !m00_axis_tready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign pkt_count   = pkt_count_q;
    assign stall_count = stall_count_q;
`else
    // final_beat only feeds the statistics counters.
    logic unused_final_beat;
    assign unused_final_beat = final_beat;
`endif

endmodule

// File: tb/tb_axis_pkt_source.sv
// Testbench for axis_pkt_source: table-driven packets, hand-written corner
// sequences and a randomized run, all checked every cycle against a
// queue-based model of the expected beat stream.

module tb_axis_pkt_source;

    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] pkt_len;
    logic [31:0]   start_value;
    logic [31:0]   stride;
    logic          busy;
    logic          done;
    logic [31:0]   tdata;
    logic [3:0]    tstrb;
    logic          tvalid;
    logic          tready;
    logic          tlast;
`ifdef AXIS_PKT_SOURCE_STATS_EN
    logic [31:0]   pkt_count;
    logic [31:0]   stall_count;
`endif

    always #5 clk = ~clk;

    axis_pkt_source #(
        .C_M00_AXIS_TDATA_WIDTH(32),
        .LEN_WIDTH             (LW)
    ) dut (
        .m00_axis_aclk  (clk),
        .m00_axis_areset(rst),
        .start          (start),
        .pkt_len        (pkt_len),
        .start_value    (start_value),
        .stride         (stride),
        .busy           (busy),
        .done           (done),
        .m00_axis_tdata (tdata),
        .m00_axis_tstrb (tstrb),
        .m00_axis_tvalid(tvalid),
        .m00_axis_tready(tready),
        .m00_axis_tlast (tlast)
`ifdef AXIS_PKT_SOURCE_STATS_EN
        ,
        .pkt_count      (pkt_count),
        .stall_count    (stall_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: beats still owed to the stream, and the per-cycle done value of
    // the post-packet window (each entry = one busy cycle).
    logic [31:0] exp_q[$];
    bit          done_seq[$];
    logic [31:0] m_pkt   = 0;
    logic [31:0] m_stall = 0;
    int          hs_count;
    logic [31:0] hs_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_update();
        bit idle;
        if (rst) begin
            exp_q.delete();
            done_seq.delete();
            m_pkt   = 0;
            m_stall = 0;
        end else begin
            idle = (exp_q.size() == 0) && (done_seq.size() == 0);
            if (tvalid === 1'b1 && tready) begin
                hs_count++;
                hs_last = tdata;
            end
            if (exp_q.size() > 0) begin
                if (!tready) begin
                    m_stall++;
                end else begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        done_seq.push_back(1'b1);
                        m_pkt++;
                    end
                end
            end else if (done_seq.size() > 0) begin
                void'(done_seq.pop_front());
            end
            if (idle && start) begin
                if (pkt_len == 0) begin
                    done_seq.push_back(1'b0);
                    done_seq.push_back(1'b1);
                end else begin
                    for (int i = 0; i < int'(pkt_len); i++) begin
                        exp_q.push_back(start_value + stride * 32'(i));
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("tvalid", {31'd0, tvalid}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            check("tdata", tdata, exp_q[0]);
            check("tlast", {31'd0, tlast}, {31'd0, exp_q.size() == 1});
        end else begin
            check("tlast_idle", {31'd0, tlast}, 32'd0);
        end
        check("done", {31'd0, done}, {31'd0, (done_seq.size() > 0) && done_seq[0]});
        check("busy", {31'd0, busy}, {31'd0, (exp_q.size() > 0) || (done_seq.size() > 0)});
        check("tstrb", {28'd0, tstrb}, 32'hF);
`ifdef AXIS_PKT_SOURCE_STATS_EN
        check("pkt_count", pkt_count, m_pkt);
        check("stall_count", stall_count, m_stall);
`endif
    endtask

    // Inputs are set on the falling edge; one tick = one rising edge.
    task automatic tick();
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        logic [31:0] sv;
        logic [31:0] stride;
        logic [15:0] len;
        logic [15:0] stall;       // bit k set: tready low in cycle k+1 after start
        logic [31:0] exp_last;
        int          exp_beats;
        int          exp_done_cyc; // cycle after the start edge in which done is high
    } vec_t;

    vec_t vecs[6];

    initial begin
        int done_cyc;
        int c;

        vecs[0] = '{32'd1,          32'd1,          16'd5, 16'h0000, 32'd5,          5, 6};
        vecs[1] = '{32'd100,        32'd100,        16'd5, 16'h0006, 32'd500,        5, 8};
        vecs[2] = '{32'hFFFF_FFFE,  32'd1,          16'd3, 16'h0000, 32'h0000_0000,  3, 4};
        vecs[3] = '{32'd42,         32'd9,          16'd1, 16'h0000, 32'd42,         1, 2};
        vecs[4] = '{32'd55,         32'd1,          16'd0, 16'h0000, 32'd0,          0, 2};
        vecs[5] = '{32'h8000_0000,  32'h8000_0001,  16'd4, 16'h000A, 32'h0000_0003,  4, 7};

        rst = 1'b1; start = 1'b0; pkt_len = '0; start_value = '0; stride = '0; tready = 1'b0;
        hs_count = 0; hs_last = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_tdata", tdata, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven packets.
        foreach (vecs[v]) begin
            start = 1'b1; start_value = vecs[v].sv; stride = vecs[v].stride;
            pkt_len = vecs[v].len; tready = 1'b1;
            hs_count = 0; done_cyc = -1;
            tick();
            start = 1'b0;
            c = 1;
            while (done_cyc < 0 && c <= 40) begin
                if (done) done_cyc = c;
                tready = (c <= 16) ? !vecs[v].stall[c-1] : 1'b1;
                tick();
                c++;
            end
            check("vec_done_cycle", done_cyc, vecs[v].exp_done_cyc);
            check("vec_beats", hs_count, vecs[v].exp_beats);
            if (vecs[v].exp_beats > 0) check("vec_last", hs_last, vecs[v].exp_last);
            tick();
        end

        // Reset mid-packet, then a fresh packet straight after reset.
        start = 1'b1; start_value = 32'd1; stride = 32'd1; pkt_len = 16'd5; tready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_tvalid", {31'd0, tvalid}, 32'd0);
        check("abort_tdata", tdata, 32'd0);
        rst = 1'b0; start = 1'b1; start_value = 32'd7; stride = 32'd1; pkt_len = 16'd2;
        hs_count = 0;
        tick();
        start = 1'b0;
        check("post_rst_first", tdata, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_beats", hs_count, 32'd2);
        check("post_rst_last", hs_last, 32'd8);

        // Start pulsed during SEND and again in DONE: both ignored.
        start = 1'b1; start_value = 32'd10; stride = 32'd5; pkt_len = 16'd3; tready = 1'b1;
        hs_count = 0;
        tick();
        start = 1'b1; start_value = 32'd999; pkt_len = 16'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ign_done", {31'd0, done}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("ign_beats", hs_count, 32'd3);
        check("ign_last", hs_last, 32'd20);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 3) == 0);
            pkt_len     = LW'($urandom_range(0, 6));
            start_value = $urandom;
            stride      = $urandom;
            tready      = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0; start = 1'b0; tready = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
